// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter sharing one opcode/addr SPI serializer among NREQ request queues.
// Latency: grant edge T -> ser_valid high during T+1; next grant no earlier than 1 cycle after ser_ready returns.
// Backpressure: req_ready only while idle and ser_ready=1; pending requests wait (never dropped) while busy.
//
// Ports:
//   clk, rst_n            fast system clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_opcode/req_addr   flattened per-requester payload (requester i at [i*W +: W])
//   ser_valid             one-cycle load pulse to the serializer
//   ser_opcode/ser_addr   payload latched at grant, held until the next grant
//   ser_ready             serializer ready_out (low while shifting)
//   busy                  high from grant until the shift-out has finished
//   grant_id              index of the last granted requester
//   err_timeout/err_clr   sticky stall flag and its clear
//
// Build option: define SER_ARB_TIMEOUT_EN to build the BUSY stall counter that
// drives err_timeout. Without it err_timeout is tied low and err_clr is ignored.
module ser_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDRW       = 8,
  parameter int OPCODEW     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*OPCODEW-1:0]    req_opcode,
  input  logic [NREQ*ADDRW-1:0]      req_addr,
  output logic                       ser_valid,
  output logic [OPCODEW-1:0]         ser_opcode,
  output logic [ADDRW-1:0]           ser_addr,
  input  logic                       ser_ready,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_BUSY
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               ser_valid_q, ser_valid_d;
  logic [OPCODEW-1:0] ser_opcode_q, ser_opcode_d;
  logic [ADDRW-1:0]   ser_addr_q, ser_addr_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     cand;
  logic               grant;
  logic [OPCODEW-1:0] sel_opcode;
  logic [ADDRW-1:0]   sel_addr;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign sel_opcode = req_opcode[win_idx*OPCODEW +: OPCODEW];
  assign sel_addr   = req_addr[win_idx*ADDRW +: ADDRW];

  // Handshake only when the serializer can take a load right away.
  assign grant = (state_q == S_IDLE) && ser_ready && win_found;

  // Gated by rst_n so nothing is accepted while reset is asserted.
  assign req_ready = (grant && rst_n) ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ser_valid_d  = 1'b0;
    ser_opcode_d = ser_opcode_q;
    ser_addr_d   = ser_addr_q;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          ser_opcode_d = sel_opcode;
          ser_addr_d   = sel_addr;
          grant_id_d   = win_idx;
          busy_d       = 1'b1;
          ptr_d        = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          ser_valid_d  = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        // Ready still high means the serializer did not take the load: re-pulse.
        if (ser_ready) begin
          ser_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ser_ready) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      ser_valid_q  <= 1'b0;
      ser_opcode_q <= '0;
      ser_addr_q   <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ser_valid_q  <= ser_valid_d;
      ser_opcode_q <= ser_opcode_d;
      ser_addr_q   <= ser_addr_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign ser_valid  = ser_valid_q;
  assign ser_opcode = ser_opcode_q;
  assign ser_addr   = ser_addr_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

`ifdef SER_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  // Counter restarts on entry to BUSY, counts BUSY cycles and saturates at the limit.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == S_WAIT_LO && !ser_ready) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_BUSY && tmo_cnt_q != TMO_LIM) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
      if (tmo_cnt_d == TMO_LIM) begin
        err_timeout_d = 1'b1;
      end
    end
    // Clear has priority over a set in the same cycle.
    if (err_clr) begin
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr ^ (TIMEOUT_CYC != 0);
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ser_tx_arbiter.sv
module tb_ser_tx_arbiter;
  localparam int NREQ = 4;
  localparam int ADDRW = 8;
  localparam int OPCODEW = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*OPCODEW-1:0] req_opcode;
  logic [NREQ*ADDRW-1:0]   req_addr;
  logic                    ser_valid;
  logic [OPCODEW-1:0]      ser_opcode;
  logic [ADDRW-1:0]        ser_addr;
  logic                    ser_ready;
  logic                    busy;
  logic [1:0]              grant_id;
  logic                    err_timeout;
  logic                    err_clr;

  ser_tx_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .OPCODEW(OPCODEW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr(req_addr), .ser_valid(ser_valid),
    .ser_opcode(ser_opcode), .ser_addr(ser_addr), .ser_ready(ser_ready),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  int          m_ptr;
  bit          m_idle;
  bit          m_loaded;     // serializer accepted the load, shift in progress
  int          m_vld_in;     // samples until the next expected load pulse (-1: none)
  logic [1:0]  m_op;
  logic [7:0]  m_addr;
  int          m_id;
  int          gid_log[$];
  logic [3:0]  granted;

  // Serializer model
  bit miss_next;
  bit ser_hold;
  bit arm;
  int low_len;
  int low_cnt;

  function automatic int winner(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_idle = 1; m_loaded = 0; m_vld_in = -1;
    m_op = '0; m_addr = '0; m_id = 0;
    arm = 0; low_cnt = 0; miss_next = 0; ser_ready = 1'b1;
  endtask

  task automatic new_data(input int i);
    req_opcode[i*OPCODEW +: OPCODEW] = 2'($urandom);
    req_addr[i*ADDRW +: ADDRW] = 8'($urandom);
  endtask

  // One clock: sample/check at negedge, advance model, step serializer after posedge.
  task automatic cycle();
    int w;
    logic [3:0] exp_rr;
    @(negedge clk);
    exp_rr = '0;
    w = winner(m_ptr, req_valid);
    if (m_idle && ser_ready && w >= 0) exp_rr = 4'(1 << w);
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("ser_valid", 32'(ser_valid), 32'(m_vld_in == 0));
    chk("ser_opcode", 32'(ser_opcode), 32'(m_op));
    chk("ser_addr", 32'(ser_addr), 32'(m_addr));
    chk("grant_id", 32'(grant_id), 32'(m_id));
`ifndef SER_ARB_TIMEOUT_EN
    chk("err_timeout_off", 32'(err_timeout), 32'(0));
`endif
    if (m_vld_in == 0) begin
      if (ser_ready && !miss_next) begin
        arm = 1; m_loaded = 1; m_vld_in = -1;
      end else begin
        miss_next = 0; m_vld_in = 1;
      end
    end else if (m_vld_in > 0) begin
      m_vld_in--;
    end else if (m_loaded && ser_ready) begin
      m_loaded = 0; m_idle = 1;
    end
    granted = exp_rr;
    if (exp_rr != 0) begin
      m_idle = 0; m_ptr = (w + 1) % NREQ; m_vld_in = 0; m_id = w;
      m_op = req_opcode[w*OPCODEW +: OPCODEW];
      m_addr = req_addr[w*ADDRW +: ADDRW];
      gid_log.push_back(w);
    end
    @(posedge clk); #1;
    if (arm) begin
      arm = 0; ser_ready = 1'b0; low_cnt = low_len;
    end else if (low_cnt > 0 && !ser_hold) begin
      low_cnt--;
      if (low_cnt == 0) ser_ready = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && !(m_idle && ser_ready); i++) cycle();
    chk(tag, 32'(m_idle && ser_ready), 32'(1));
  endtask

  initial begin
    int ngr;
    logic [3:0] exp_fair[8];
    rst_n = 1'b0; err_clr = 1'b0; ser_hold = 0; low_len = 3;
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) new_data(i);
    model_reset();

    // Reset with all requesters valid
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_ser_valid", 32'(ser_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_ser_addr", 32'(ser_addr), 32'(0));
    chk("rst_err", 32'(err_timeout), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;

    // Single request from requester 2
    req_valid = 4'b0100; req_opcode[5:4] = 2'b10; req_addr[23:16] = 8'hA5; low_len = 4;
    cycle();
    chk("single_grant", 32'(granted), 32'(4'b0100));
    req_valid = '0;
    repeat (10) cycle();
    chk("single_opcode", 32'(ser_opcode), 32'(2'b10));
    chk("single_addr", 32'(ser_addr), 32'(8'hA5));
    chk("single_id", 32'(grant_id), 32'(2));

    // Fairness: all valid for 8 transfers, starting from ptr=0
    apply_reset();
    gid_log.delete();
    req_valid = 4'hF; low_len = 2;
    for (int i = 0; i < 400 && gid_log.size() < 8; i++) begin
      cycle();
      for (int r = 0; r < NREQ; r++) if (granted[r]) new_data(r);
    end
    exp_fair = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
    chk("fair_count", 32'(gid_log.size() >= 8), 32'(1));
    for (int k = 0; k < 8 && k < gid_log.size(); k++)
      chk($sformatf("fair_seq%0d", k), 32'(gid_log[k]), 32'(exp_fair[k]));
    req_valid = '0;
    wait_idle("fair_drain");

    // Wrap and skip: grant requester 2 to put ptr at 3, then 0011, then 2 arrives mid-BUSY
    req_valid = 4'b0100; new_data(2);
    for (int i = 0; i < 20 && granted == 0; i++) cycle();
    req_valid = '0;
    wait_idle("wrap_setup");
    gid_log.delete();
    low_len = 6;
    req_valid = 4'b0011; new_data(0); new_data(1);
    for (int i = 0; i < 300 && gid_log.size() < 3; i++) begin
      cycle();
      for (int r = 0; r < NREQ; r++) if (granted[r]) req_valid[r] = 1'b0;
      if (gid_log.size() == 1 && busy && !ser_ready && !req_valid[2]) begin
        req_valid[2] = 1'b1; new_data(2);
      end
    end
    chk("wrap_count", 32'(gid_log.size()), 32'(3));
    if (gid_log.size() == 3) begin
      chk("wrap_first", 32'(gid_log[0]), 32'(0));
      chk("wrap_second", 32'(gid_log[1]), 32'(1));
      chk("wrap_third", 32'(gid_log[2]), 32'(2));
    end
    wait_idle("wrap_drain");

    // Reset mid-BUSY: ptr must return to 0
    low_len = 30;
    req_valid = 4'b0100; new_data(2);
    for (int i = 0; i < 20 && granted == 0; i++) cycle();
    req_valid = '0;
    repeat (6) cycle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_ser_valid", 32'(ser_valid), 32'(0));
    chk("midrst_req_ready", 32'(req_ready), 32'(0));
    chk("midrst_grant_id", 32'(grant_id), 32'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; low_len = 3;
    gid_log.delete();
    req_valid = 4'b1010; new_data(1); new_data(3);
    for (int i = 0; i < 20 && gid_log.size() == 0; i++) cycle();
    req_valid = '0;
    chk("midrst_next_grant", 32'(gid_log.size() > 0 ? gid_log[0] : -1), 32'(1));
    wait_idle("midrst_drain");

    // Stall with ser_ready held low
    ser_hold = 1; low_len = 5;
    req_valid = 4'b0001; new_data(0);
    for (int i = 0; i < 20 && !m_loaded; i++) cycle();
    req_valid = '0;
    cycle();
    repeat (10) cycle();
    chk("tmo_early", 32'(err_timeout), 32'(0));
    repeat (10) cycle();
`ifdef SER_ARB_TIMEOUT_EN
    chk("tmo_set", 32'(err_timeout), 32'(1));
`else
    chk("tmo_off", 32'(err_timeout), 32'(0));
`endif
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("tmo_clr", 32'(err_timeout), 32'(0));
    ser_hold = 0;
    wait_idle("tmo_drain");

    // Randomized traffic
    gid_log.delete();
    for (int c = 0; c < 3000; c++) begin
      if (!arm && low_cnt == 0) low_len = 1 + int'($urandom_range(5));
      if (!miss_next && $urandom_range(9) == 0) miss_next = 1;
      cycle();
      for (int r = 0; r < NREQ; r++) begin
        if (granted[r]) begin
          req_valid[r] = 1'($urandom);
          new_data(r);
        end else if (req_valid[r]) begin
          if ($urandom_range(19) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[r] = 1'b1;
          new_data(r);
        end
      end
    end
    ngr = gid_log.size();
    chk("rand_progress", 32'(ngr > 50), 32'(1));
    req_valid = '0;
    miss_next = 0;
    wait_idle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
